// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - requester channel between a bus master and the dmem port arbiter
//
// Purpose: one request/response channel. The requester drives the request fields and
// holds them until ack; the arbiter returns a one-cycle ack with rdata/err.
// Signals:
//   req    request, level, held until ack
//   we     write enable
//   addr   byte address
//   wdata  write data
//   ack    one-cycle completion pulse
//   rdata  read data, valid with ack
//   err    error flag, valid with ack
// Modports: master (requester side), slave (arbiter side).
interface dmem_port_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, addr, wdata, input ack, rdata, err);
  modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - round-robin arbiter and sequencer for the data-memory/MMIO slave port
//
// Purpose: shares one slave port between the load/store unit (m0) and the debug/host
// port (m1). Holds the slave command stable until s_ready, aborts stuck accesses after
// TIMEOUT cycles, and parks the slave address on a RAM address while idle.
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   m0, m1       requester channels (req/we/addr/wdata in, ack/rdata/err out)
//   s_we         slave write enable
//   s_addr       slave address
//   s_wdata      slave write data
//   s_rdata      slave read data
//   s_ready      slave access complete
//   s_error      slave error, valid with s_ready
//   busy         high while an access is in flight
//   timeout_cnt  saturating count of watchdog aborts
module dmem_port_arbiter #(
  parameter int unsigned  TIMEOUT   = 64,
  parameter logic [31:0]  PARK_ADDR = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_port_arbiter_if.slave   m0,
  dmem_port_arbiter_if.slave   m1,
  output logic                 s_we,
  output logic [31:0]          s_addr,
  output logic [31:0]          s_wdata,
  input  logic [31:0]          s_rdata,
  input  logic                 s_ready,
  input  logic                 s_error,
  output logic                 busy,
  output logic [7:0]           timeout_cnt
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [7:0]  WDOG_LAST   = 8'(TIMEOUT - 1);
  localparam logic [31:0] ABORT_RDATA = 32'hDEAD_BEEF;

  state_t      state;
  logic        owner;       // 0: m0 holds the slave port, 1: m1
  logic        last_grant;  // requester granted most recently
  logic [7:0]  wdog;
  logic        pick1;
  logic        finish;
  logic [31:0] resp_rdata;
  logic        resp_err;

  // m1 wins when it asks alone, or when both ask and m0 was served last.
  always_comb begin
    pick1 = m1.req && (!m0.req || !last_grant);
  end

  // A response arriving on the watchdog's last cycle completes normally.
  always_comb begin
    finish     = s_ready || (wdog == WDOG_LAST);
    resp_rdata = s_ready ? s_rdata : ABORT_RDATA;
    resp_err   = s_ready ? s_error : 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      wdog        <= '0;
      s_we        <= 1'b0;
      s_addr      <= PARK_ADDR;
      s_wdata     <= '0;
      busy        <= 1'b0;
      timeout_cnt <= '0;
      m0.ack      <= 1'b0;
      m0.err      <= 1'b0;
      m0.rdata    <= '0;
      m1.ack      <= 1'b0;
      m1.err      <= 1'b0;
      m1.rdata    <= '0;
    end else begin
      m0.ack <= 1'b0;
      m1.ack <= 1'b0;
      case (state)
        IDLE: begin
          if (m0.req || m1.req) begin
            owner      <= pick1;
            last_grant <= pick1;
            s_we       <= pick1 ? m1.we    : m0.we;
            s_addr     <= pick1 ? m1.addr  : m0.addr;
            s_wdata    <= pick1 ? m1.wdata : m0.wdata;
            wdog       <= '0;
            busy       <= 1'b1;
            state      <= ACCESS;
          end else begin
            s_we   <= 1'b0;
            s_addr <= PARK_ADDR;
          end
        end
        ACCESS: begin
          if (finish) begin
            if (owner) begin
              m1.ack   <= 1'b1;
              m1.rdata <= resp_rdata;
              m1.err   <= resp_err;
            end else begin
              m0.ack   <= 1'b1;
              m0.rdata <= resp_rdata;
              m0.err   <= resp_err;
            end
            if (!s_ready && timeout_cnt != 8'hFF) begin
              timeout_cnt <= timeout_cnt + 8'd1;
            end
            s_we   <= 1'b0;
            s_addr <= PARK_ADDR;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;
  localparam int          TMO  = 8;
  localparam logic [31:0] PARK = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_we;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata;
  logic        s_ready = 1'b0;
  logic        s_error = 1'b0;
  logic        busy;
  logic [7:0]  timeout_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter_if m0_if ();
  dmem_port_arbiter_if m1_if ();

  dmem_port_arbiter #(.TIMEOUT(TMO), .PARK_ADDR(PARK)) dut (
    .clk         (clk),
    .rst         (rst_n),
    .m0          (m0_if),
    .m1          (m1_if),
    .s_we        (s_we),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_rdata     (s_rdata),
    .s_ready     (s_ready),
    .s_error     (s_error),
    .busy        (busy),
    .timeout_cnt (timeout_cnt)
  );

  // Slave: word memory, s_ready after wait_cycles ACCESS cycles (255 = never).
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  int          wait_cycles = 0;
  logic        err_val = 1'b0;
  int          acc_cyc = 0;
  logic [7:0]  exp_tcnt = 8'd0;

  assign s_rdata = mem[s_addr[9:2]];

  always @(negedge clk) begin
    if (busy) begin
      s_ready = (acc_cyc == wait_cycles);
      s_error = s_ready ? err_val : 1'b0;
      acc_cyc++;
    end else begin
      s_ready = 1'b0;
      s_error = 1'b0;
      acc_cyc = 0;
    end
  end

  always @(posedge clk) begin
    if (busy && s_ready && s_we) mem[s_addr[9:2]] <= s_wdata;
  end

  task automatic drive_m0(input logic req, input logic we, input logic [31:0] a, input logic [31:0] wd);
    m0_if.req = req; m0_if.we = we; m0_if.addr = a; m0_if.wdata = wd;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic [31:0] a, input logic [31:0] wd);
    m1_if.req = req; m1_if.we = we; m1_if.addr = a; m1_if.wdata = wd;
  endtask

  task automatic do_reset();
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_tcnt = 8'd0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({s_we, s_addr, s_wdata, busy, timeout_cnt} !== {1'b0, PARK, 32'h0, 1'b0, 8'h0}) begin
      errors++;
      $display("FAIL reset_slave got we=%b addr=%h wd=%h busy=%b tcnt=%0d exp we=0 addr=%h wd=0 busy=0 tcnt=0",
               s_we, s_addr, s_wdata, busy, timeout_cnt, PARK);
    end
    checks++;
    if ({m0_if.ack, m0_if.err, m0_if.rdata, m1_if.ack, m1_if.err, m1_if.rdata} !== 68'h0) begin
      errors++;
      $display("FAIL reset_req got m0 ack=%b err=%b rd=%h m1 ack=%b err=%b rd=%h exp all 0",
               m0_if.ack, m0_if.err, m0_if.rdata, m1_if.ack, m1_if.err, m1_if.rdata);
    end
  endtask

  task automatic test_single_read();
    mem[5] = 32'h11; ref_mem[5] = 32'h11;
    wait_cycles = 0; err_val = 1'b0;
    drive_m0(1'b1, 1'b0, 32'h14, 32'h0);
    @(negedge clk);
    checks++;
    if ({s_addr, s_we, busy, m0_if.ack} !== {32'h14, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL read_access got addr=%h we=%b busy=%b ack=%b exp addr=00000014 we=0 busy=1 ack=0",
               s_addr, s_we, busy, m0_if.ack);
    end
    @(negedge clk);
    checks++;
    if ({m0_if.ack, m0_if.rdata, m0_if.err, s_addr, busy} !== {1'b1, 32'h11, 1'b0, PARK, 1'b0}) begin
      errors++;
      $display("FAIL read_ack got ack=%b rd=%h err=%b addr=%h busy=%b exp ack=1 rd=00000011 err=0 addr=%h busy=0",
               m0_if.ack, m0_if.rdata, m0_if.err, s_addr, busy, PARK);
    end
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (m0_if.ack !== 1'b0) begin
      errors++;
      $display("FAIL read_ack_pulse got ack=%b exp 0", m0_if.ack);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    do_reset();
    wait_cycles = 0; err_val = 1'b0;
    drive_m0(1'b1, 1'b0, 32'h20, 32'h0);
    drive_m1(1'b1, 1'b0, 32'h24, 32'h0);
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      @(negedge clk);
      if (m0_if.ack && m1_if.ack) begin
        checks++; errors++;
        $display("FAIL rr_double_ack got both acks exp one");
      end
      if (m0_if.ack) order.push_back(0);
      if (m1_if.ack) order.push_back(1);
    end
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (order.size() != 4) begin
      errors++;
      $display("FAIL rr_count got %0d acks exp 4", order.size());
    end
    foreach (order[i]) begin
      checks++;
      if (order[i] != i % 2) begin
        errors++;
        $display("FAIL rr_order ack %0d got m%0d exp m%0d", i, order[i], i % 2);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_wait_states();
    logic [31:0] old1;
    int bad;
    old1 = ref_mem[1];
    wait_cycles = 5; err_val = 1'b1;
    drive_m1(1'b1, 1'b1, 32'h1000_0004, 32'hCAFE_0001);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) drive_m0(1'b1, 1'b0, 32'h30, 32'h0);
      if ({s_addr, s_we, s_wdata, busy, m0_if.ack, m1_if.ack} !== {32'h1000_0004, 1'b1, 32'hCAFE_0001, 1'b1, 1'b0, 1'b0})
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wait_hold got %0d unstable cycles exp 0", bad);
    end
    @(negedge clk);
    checks++;
    if ({m1_if.ack, m1_if.err, m1_if.rdata, m0_if.ack} !== {1'b1, 1'b1, old1, 1'b0}) begin
      errors++;
      $display("FAIL wait_ack got m1 ack=%b err=%b rd=%h m0 ack=%b exp m1 ack=1 err=1 rd=%h m0 ack=0",
               m1_if.ack, m1_if.err, m1_if.rdata, m0_if.ack, old1);
    end
    ref_mem[1] = 32'hCAFE_0001;
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
    wait_cycles = 0; err_val = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_addr, busy} !== {32'h30, 1'b1}) begin
      errors++;
      $display("FAIL deferred_grant got addr=%h busy=%b exp addr=00000030 busy=1", s_addr, busy);
    end
    @(negedge clk);
    checks++;
    if ({m0_if.ack, m0_if.rdata, m0_if.err, m1_if.rdata} !== {1'b1, ref_mem[12], 1'b0, old1}) begin
      errors++;
      $display("FAIL deferred_ack got ack=%b rd=%h err=%b m1rd=%h exp ack=1 rd=%h err=0 m1rd=%h",
               m0_if.ack, m0_if.rdata, m0_if.err, m1_if.rdata, ref_mem[12], old1);
    end
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int bad;
    wait_cycles = 255; err_val = 1'b0;
    drive_m0(1'b1, 1'b0, 32'h08, 32'h0);
    bad = 0;
    for (int c = 0; c < TMO; c++) begin
      @(negedge clk);
      if ({busy, m0_if.ack} !== 2'b10) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL timeout_window got %0d bad cycles exp 0", bad);
    end
    @(negedge clk);
    exp_tcnt = exp_tcnt + 8'd1;
    checks++;
    if ({m0_if.ack, m0_if.err, m0_if.rdata, timeout_cnt, s_addr, s_we} !==
        {1'b1, 1'b1, 32'hDEAD_BEEF, exp_tcnt, PARK, 1'b0}) begin
      errors++;
      $display("FAIL timeout_abort got ack=%b err=%b rd=%h tcnt=%0d addr=%h we=%b exp ack=1 err=1 rd=deadbeef tcnt=%0d addr=%h we=0",
               m0_if.ack, m0_if.err, m0_if.rdata, timeout_cnt, s_addr, s_we, exp_tcnt, PARK);
    end
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_ready_at_expiry();
    int bad;
    wait_cycles = TMO - 1; err_val = 1'b0;
    drive_m0(1'b1, 1'b0, 32'h0C, 32'h0);
    bad = 0;
    for (int c = 0; c < TMO; c++) begin
      @(negedge clk);
      if (m0_if.ack !== 1'b0) bad++;
    end
    @(negedge clk);
    checks++;
    if (bad != 0 || {m0_if.ack, m0_if.err, m0_if.rdata, timeout_cnt} !== {1'b1, 1'b0, ref_mem[3], exp_tcnt}) begin
      errors++;
      $display("FAIL expiry_race got early=%0d ack=%b err=%b rd=%h tcnt=%0d exp early=0 ack=1 err=0 rd=%h tcnt=%0d",
               bad, m0_if.ack, m0_if.err, m0_if.rdata, timeout_cnt, ref_mem[3], exp_tcnt);
    end
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    int first;
    logic [31:0] old4;
    old4 = ref_mem[4];
    wait_cycles = 255; err_val = 1'b0;
    drive_m0(1'b1, 1'b1, 32'h10, 32'h5A5A_0004);
    repeat (3) @(negedge clk);
    checks++;
    if ({s_we, busy} !== 2'b11) begin
      errors++;
      $display("FAIL mid_access got we=%b busy=%b exp we=1 busy=1", s_we, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_we, busy, s_addr} !== {1'b0, 1'b0, PARK}) begin
      errors++;
      $display("FAIL async_reset got we=%b busy=%b addr=%h exp we=0 busy=0 addr=%h", s_we, busy, s_addr, PARK);
    end
    exp_tcnt = 8'd0;
    @(negedge clk);
    checks++;
    if ({m0_if.ack, m1_if.ack, busy, timeout_cnt} !== {1'b0, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_hold got ack0=%b ack1=%b busy=%b tcnt=%0d exp 0 0 0 0",
               m0_if.ack, m1_if.ack, busy, timeout_cnt);
    end
    wait_cycles = 0;
    drive_m1(1'b1, 1'b0, 32'h18, 32'h0);
    rst_n = 1'b1;
    first = -1;
    for (int c = 0; c < 20 && first < 0; c++) begin
      @(negedge clk);
      if (m0_if.ack) first = 0;
      else if (m1_if.ack) first = 1;
    end
    checks++;
    if (first != 0 || m0_if.rdata !== old4) begin
      errors++;
      $display("FAIL post_reset_grant got first=m%0d rd=%h exp first=m0 rd=%h", first, m0_if.rdata, old4);
    end
    ref_mem[4] = 32'h5A5A_0004;
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  // Continuous contention, random transactions and slave latencies.
  // Model: grants alternate m0/m1; reads return the model memory; err follows the slave.
  logic        cur_we   [2];
  logic [31:0] cur_addr [2];
  logic [31:0] cur_wd   [2];
  logic        exp_err;

  task automatic load_txn(input int r);
    cur_addr[r] = {22'($urandom), 4'h0, 4'($urandom_range(0, 15)), 2'b00};
    cur_we[r]   = 1'($urandom_range(0, 1));
    cur_wd[r]   = $urandom;
    if (r == 0) drive_m0(1'b1, cur_we[0], cur_addr[0], cur_wd[0]);
    else        drive_m1(1'b1, cur_we[1], cur_addr[1], cur_wd[1]);
  endtask

  task automatic new_slave_cfg();
    wait_cycles = $urandom_range(0, TMO - 1);
    err_val     = 1'($urandom_range(0, 1));
    exp_err     = err_val;
  endtask

  task automatic test_random();
    int exp_owner, done, r;
    logic [31:0] got_rd, exp_rd;
    logic got_err;
    do_reset();
    exp_owner = 0;
    done = 0;
    new_slave_cfg();
    load_txn(0);
    load_txn(1);
    for (int c = 0; c < 1500 && done < 40; c++) begin
      @(negedge clk);
      if (m0_if.ack || m1_if.ack) begin
        checks++;
        if (m0_if.ack && m1_if.ack) begin
          errors++;
          $display("FAIL rand_double_ack got both exp one");
        end
        r = m1_if.ack ? 1 : 0;
        checks++;
        if (r != exp_owner) begin
          errors++;
          $display("FAIL rand_owner txn %0d got m%0d exp m%0d", done, r, exp_owner);
        end
        got_rd  = r ? m1_if.rdata : m0_if.rdata;
        got_err = r ? m1_if.err : m0_if.err;
        exp_rd  = ref_mem[cur_addr[r][9:2]];
        checks++;
        if (got_rd !== exp_rd || got_err !== exp_err) begin
          errors++;
          $display("FAIL rand_resp txn %0d got rd=%h err=%b exp rd=%h err=%b", done, got_rd, got_err, exp_rd, exp_err);
        end
        if (cur_we[r]) ref_mem[cur_addr[r][9:2]] = cur_wd[r];
        exp_owner = 1 - exp_owner;
        done++;
        new_slave_cfg();
        load_txn(r);
      end
    end
    checks++;
    if (done != 40) begin
      errors++;
      $display("FAIL rand_progress got %0d acks exp 40", done);
    end
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hA500_0000 + 32'(i);
      ref_mem[i] = 32'hA500_0000 + 32'(i);
    end
    test_reset();
    test_single_read();
    test_round_robin();
    test_wait_states();
    test_timeout();
    test_ready_at_expiry();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_time_limit reached exp finish earlier");
    $fatal(1, "time limit");
  end

endmodule
